// File: rtl/writeback_stage.sv
// MEM/WB stage register and register-file writeback logic.
// Extracts load data, flags load faults and counts retired instructions.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [4:0]       RdM,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    output logic             ValidW,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic             LoadErrW,
    output logic [CNT_W-1:0] InstRetW
);

    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    logic [1:0]       resultsrc_q, resultsrc_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  aluresult_q, aluresult_d;
    logic [XLEN-1:0]  readdata_q, readdata_d;
    logic [XLEN-1:0]  pcplus4_q, pcplus4_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic            ld_fault;
    logic            is_load;

    // Next stage contents: flush beats stall, stall beats capture.
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        aluresult_d = aluresult_q;
        readdata_d  = readdata_q;
        pcplus4_d   = pcplus4_q;
        if (FlushW) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            resultsrc_d = '0;
            funct3_d    = '0;
            rd_d        = '0;
            aluresult_d = '0;
            readdata_d  = '0;
            pcplus4_d   = '0;
        end else if (!StallW) begin
            valid_d     = ValidM;
            regwrite_d  = RegWriteM;
            resultsrc_d = ResultSrcM;
            funct3_d    = Funct3M;
            rd_d        = RdM;
            aluresult_d = ALUResultM;
            readdata_d  = ReadDataM;
            pcplus4_d   = PCPlus4M;
        end
    end

    // An instruction retires when it leaves W, faulting or not.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !StallW) begin
            instret_d = instret_q + 1'b1;
        end
    end

    // Stage register and retirement counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            pcplus4_q   <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            pcplus4_q   <= pcplus4_d;
            instret_q   <= instret_d;
        end
    end

    assign off     = aluresult_q[1:0];
    assign ld_half = off[1] ? readdata_q[31:16] : readdata_q[15:0];
    assign is_load = (resultsrc_q == 2'b01);

    // Little-endian byte select and load sign/zero extension.
    always_comb begin
        unique case (off)
            2'd0: ld_byte = readdata_q[7:0];
            2'd1: ld_byte = readdata_q[15:8];
            2'd2: ld_byte = readdata_q[23:16];
            2'd3: ld_byte = readdata_q[31:24];
        endcase
        ld_data  = '0;
        ld_fault = 1'b0;
        unique case (funct3_q)
            3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_data  = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_fault = off[0];
            end
            3'b101: begin
                ld_data  = {{(XLEN-16){1'b0}}, ld_half};
                ld_fault = off[0];
            end
            3'b010: begin
                ld_data  = readdata_q;
                ld_fault = (off != 2'd0);
            end
            default: ld_fault = 1'b1;
        endcase
    end

    assign LoadErrW = valid_q & is_load & ld_fault;

    // Writeback data select; faulting loads write nothing.
    always_comb begin
        ResultW = '0;
        unique case (resultsrc_q)
            2'b00: ResultW = aluresult_q;
            2'b01: ResultW = LoadErrW ? '0 : ld_data;
            2'b10: ResultW = pcplus4_q;
            default: ResultW = '0;
        endcase
    end

    assign ValidW    = valid_q;
    assign RdW       = rd_q;
    assign RegWriteW = valid_q & regwrite_q & (rd_q != 5'd0)
                     & ~LoadErrW & (resultsrc_q != 2'b11);
    assign InstRetW  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected
// W-stage results, a negedge monitor pops and compares them.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
    logic        ValidW, RegWriteW, LoadErrW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [63:0] InstRetW;

    logic        w_valid_m;
    logic        w_valid, w_rw, w_err;
    logic [4:0]  w_rd;
    logic [31:0] w_res;
    logic [3:0]  w_ret;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_ret = 0;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        err;
        logic [63:0] ret;
    } exp_t;
    exp_t sb[$];

    writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ValidW(ValidW),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LoadErrW(LoadErrW), .InstRetW(InstRetW)
    );

    writeback_stage #(.XLEN(32), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .StallW(1'b0), .FlushW(1'b0),
        .ValidM(w_valid_m), .RegWriteM(1'b1), .ResultSrcM(2'b00),
        .Funct3M(3'b000), .RdM(5'd2), .ALUResultM(32'h11),
        .ReadDataM(32'h0), .PCPlus4M(32'h4), .ValidW(w_valid),
        .RegWriteW(w_rw), .RdW(w_rd), .ResultW(w_res),
        .LoadErrW(w_err), .InstRetW(w_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [4:0] rd,
                        input logic [31:0] res, input logic err);
        exp_t e;
        e.rw  = rw;
        e.rd  = rd;
        e.res = res;
        e.err = err;
        e.ret = exp_ret;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic v, input logic rw,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic st,
                       input logic fl);
        ValidM     = v;
        RegWriteM  = rw;
        ResultSrcM = src;
        Funct3M    = f3;
        RdM        = rd;
        ALUResultM = alu;
        PCPlus4M   = pc4;
        StallW     = st;
        FlushW     = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid W cycle must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ValidW === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: rd=%0d res=%0h", RdW, ResultW);
                end else begin
                    e = sb.pop_front();
                    check("regwrite", {63'd0, RegWriteW}, {63'd0, e.rw});
                    check("rd", {59'd0, RdW}, {59'd0, e.rd});
                    check("result", {32'd0, ResultW}, {32'd0, e.res});
                    check("loaderr", {63'd0, LoadErrW}, {63'd0, e.err});
                    check("instret", InstRetW, e.ret);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        w_valid_m = 1'b0;
        ReadDataM = 32'h80F17F01;
        cyc(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0);
        check("rst_valid", {63'd0, ValidW}, 64'd0);
        check("rst_instret", InstRetW, 64'd0);
        reset = 1'b0;

        push(1, 5'd3, 32'hDEADBEEF, 0); exp_ret++;
        cyc(1, 1, 2'b00, 3'b000, 5'd3, 32'hDEADBEEF, 32'h0, 0, 0);
        push(0, 5'd0, 32'h00000055, 0); exp_ret++;
        cyc(1, 1, 2'b00, 3'b000, 5'd0, 32'h00000055, 32'h0, 0, 0);

        push(1, 5'd10, 32'hFFFFFF80, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b000, 5'd10, 32'h1003, 32'h0, 0, 0);
        push(1, 5'd11, 32'h00000080, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b100, 5'd11, 32'h1003, 32'h0, 0, 0);
        push(1, 5'd12, 32'hFFFF80F1, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b001, 5'd12, 32'h1002, 32'h0, 0, 0);
        push(1, 5'd13, 32'h00007F01, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b101, 5'd13, 32'h1000, 32'h0, 0, 0);
        push(1, 5'd14, 32'h80F17F01, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b010, 5'd14, 32'h1000, 32'h0, 0, 0);
        push(1, 5'd15, 32'h0000007F, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b000, 5'd15, 32'h1001, 32'h0, 0, 0);
        push(1, 5'd16, 32'h000000F1, 0); exp_ret++;
        cyc(1, 1, 2'b01, 3'b100, 5'd16, 32'h1002, 32'h0, 0, 0);

        push(0, 5'd17, 32'h0, 1); exp_ret++;
        cyc(1, 1, 2'b01, 3'b010, 5'd17, 32'h102, 32'h0, 0, 0);
        push(0, 5'd18, 32'h0, 1); exp_ret++;
        cyc(1, 1, 2'b01, 3'b001, 5'd18, 32'h101, 32'h0, 0, 0);
        push(0, 5'd19, 32'h0, 1); exp_ret++;
        cyc(1, 1, 2'b01, 3'b110, 5'd19, 32'h100, 32'h0, 0, 0);
        push(1, 5'd20, 32'h00000101, 0); exp_ret++;
        cyc(1, 1, 2'b00, 3'b011, 5'd20, 32'h101, 32'h0, 0, 0);

        push(1, 5'd1, 32'h00000104, 0);
        cyc(1, 1, 2'b10, 3'b000, 5'd1, 32'h80, 32'h104, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(1, 5'd1, 32'h00000104, 0);
            cyc(1, 1, 2'b00, 3'b000, 5'd7, 32'h999, 32'h0, 1, 0);
        end
        exp_ret++;
        push(0, 5'd4, 32'h0, 0); exp_ret++;
        cyc(1, 1, 2'b11, 3'b000, 5'd4, 32'h77, 32'h0, 0, 0);

        cyc(1, 1, 2'b00, 3'b000, 5'd8, 32'h88, 32'h0, 1, 1);
        exp_ret--;
        check("flush_stall_valid", {63'd0, ValidW}, 64'd0);
        check("flush_stall_ret", InstRetW, exp_ret);

        push(1, 5'd9, 32'h00000099, 0); exp_ret++;
        cyc(1, 1, 2'b00, 3'b000, 5'd9, 32'h99, 32'h0, 0, 0);
        cyc(1, 1, 2'b00, 3'b000, 5'd6, 32'h66, 32'h0, 0, 1);
        check("flush_valid", {63'd0, ValidW}, 64'd0);
        check("flush_ret", InstRetW, exp_ret);
        cyc(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 0, 0);
        check("bubble_ret", InstRetW, exp_ret);

        cyc(1, 1, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 0, 0);
        ValidM = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("midrst_valid", {63'd0, ValidW}, 64'd0);
        check("midrst_rw", {63'd0, RegWriteW}, 64'd0);
        check("midrst_rd", {59'd0, RdW}, 64'd0);
        check("midrst_res", {32'd0, ResultW}, 64'd0);
        check("midrst_err", {63'd0, LoadErrW}, 64'd0);
        check("midrst_ret", InstRetW, 64'd0);
        exp_ret = 0;
        @(posedge clk);
        #1 reset = 1'b0;

        w_valid_m = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("wrap_15", {60'd0, w_ret}, 64'd15);
        @(posedge clk);
        #1;
        check("wrap_0", {60'd0, w_ret}, 64'd0);
        w_valid_m = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
